// File: rtl/fpu_fmac_param_pkg.sv
// Shared encodings and helpers for the FMAC normalise/round back end.
package fpu_fmac_param_pkg;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_W  = 3;

    // Quiet NaN (sign 0, exponent all ones, fraction MSB set), right-aligned in 64 bits.
    function automatic logic [63:0] canon_nan(input int exp_w, input int mant_w);
        logic [63:0] nan_v;
        nan_v = 64'd0;
        for (int i = 0; i < 64; i++) begin
            nan_v[i] = ((i >= mant_w) && (i < mant_w + exp_w)) || (i == mant_w - 1);
        end
        return nan_v;
    endfunction

endpackage

// File: rtl/fpu_fmac_lzc.sv
// Parametrised leading-zero counter with an all-zero indication.
module fpu_fmac_lzc #(
    parameter int WIDTH = 49,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt,
    output logic             all_zero
);

    // Scan upward so the most significant set bit writes the count last.
    always_comb begin
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                cnt = CNT_W'(WIDTH - 1 - i);
            end else begin
                cnt = cnt;
            end
        end
    end

    assign all_zero = ~|vec;

endmodule

// File: rtl/fpu_fmac_normround.sv
// Two-stage elastic normalise-and-round back end for the FMAC datapath.
// Stage 1 normalises/denormalises, stage 2 rounds, packs and applies specials.
module fpu_fmac_normround
    import fpu_fmac_param_pkg::*;
#(
    parameter int EXP_W     = 8,
    parameter int MANT_W    = 23,
    parameter int MANT_IN_W = 2*MANT_W+3,
    parameter int LZC_W     = $clog2(MANT_IN_W),
    parameter int BIAS      = 2**(EXP_W-1)-1
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RI,
    input  logic                    In_Valid_SI,
    output logic                    In_Ready_SO,
    input  logic                    Sign_DI,
    input  logic [EXP_W+1:0]        Exp_DI,
    input  logic [MANT_IN_W-1:0]    Mant_DI,
    input  logic                    Sticky_SI,
    input  logic [1:0]              RM_SI,
    input  logic                    IsNaN_SI,
    input  logic                    IsInf_SI,
    output logic                    Out_Valid_SO,
    input  logic                    Out_Ready_SI,
    output logic [EXP_W+MANT_W:0]   Res_DO,
    output logic                    OF_SO,
    output logic                    UF_SO,
    output logic                    NX_SO
);

    localparam int SIG_W   = MANT_W + 1;
    localparam int RES_W   = 1 + EXP_W + MANT_W;
    localparam int EXP_INF = 2*BIAS + 1;
    localparam logic [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic [63:0]      NAN_PAT = canon_nan(EXP_W, MANT_W);

    logic                   v1_r, v2_r;
    logic                   ld2_s, acc_s;

    logic [LZC_W-1:0]       lzc_cnt_s;
    logic                   mant_zero_s;
    logic [EXP_W+1:0]       e1_s, rsh_full_s;
    logic [LZC_W-1:0]       rsh_s;
    logic [MANT_IN_W-1:0]   mant_l_s, mant_n_s;
    logic                   tiny_s, lost_s;
    logic [EXP_W:0]         exp_n_s;
    logic [SIG_W-1:0]       sig_n_s;
    logic                   rnd_n_s, stk_n_s;

    logic                   sign1_r, rnd1_r, stk1_r, tiny1_r, nan1_r, inf1_r, zero1_r;
    logic [EXP_W:0]         exp1_r;
    logic [SIG_W-1:0]       sig1_r;
    logic [1:0]             rm1_r;

    logic                   inc_s, nx_s, of_s;
    logic [SIG_W:0]         sig_rnd_s;
    logic [EXP_W+1:0]       exp_rnd_s;
    logic [RES_W-1:0]       res_s, res_r, max_s, inf_s;
    logic [FLAG_W-1:0]      flags_s, flags_r;

    assign ld2_s       = v1_r & (~v2_r | Out_Ready_SI);
    assign In_Ready_SO = ~v1_r | ~v2_r | Out_Ready_SI;
    assign acc_s       = In_Valid_SI & In_Ready_SO;

    fpu_fmac_lzc #(
        .WIDTH (MANT_IN_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .vec      (Mant_DI),
        .cnt      (lzc_cnt_s),
        .all_zero (mant_zero_s)
    );

    // Normalise: remove leading zeros, then denormalise when the exponent is not positive.
    always_comb begin
        e1_s       = Exp_DI + EXP_ONE - (EXP_W+2)'(lzc_cnt_s);
        mant_l_s   = Mant_DI << lzc_cnt_s;
        tiny_s     = e1_s[EXP_W+1] | (e1_s == {(EXP_W+2){1'b0}});
        rsh_full_s = EXP_ONE - e1_s;
        rsh_s      = {LZC_W{1'b0}};
        mant_n_s   = mant_l_s;
        lost_s     = 1'b0;
        exp_n_s    = e1_s[EXP_W:0];
        if (tiny_s) begin
            if (rsh_full_s >= (EXP_W+2)'(MANT_IN_W)) begin
                rsh_s = LZC_W'(MANT_IN_W);
            end else begin
                rsh_s = rsh_full_s[LZC_W-1:0];
            end
            mant_n_s = mant_l_s >> rsh_s;
            lost_s   = ((mant_n_s << rsh_s) != mant_l_s);
            exp_n_s  = {(EXP_W+1){1'b0}};
        end else begin
            mant_n_s = mant_l_s;
        end
        sig_n_s = mant_n_s[MANT_IN_W-1 -: SIG_W];
        rnd_n_s = mant_n_s[MANT_IN_W-1-SIG_W];
        stk_n_s = (|mant_n_s[MANT_IN_W-2-SIG_W:0]) | lost_s | Sticky_SI;
    end

    // Stage-1 register: holds the normalised fields of one accepted beat.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            v1_r    <= 1'b0;
            sign1_r <= 1'b0;
            exp1_r  <= {(EXP_W+1){1'b0}};
            sig1_r  <= {SIG_W{1'b0}};
            rnd1_r  <= 1'b0;
            stk1_r  <= 1'b0;
            tiny1_r <= 1'b0;
            rm1_r   <= 2'd0;
            nan1_r  <= 1'b0;
            inf1_r  <= 1'b0;
            zero1_r <= 1'b0;
        end else if (acc_s) begin
            v1_r    <= 1'b1;
            sign1_r <= Sign_DI;
            exp1_r  <= exp_n_s;
            sig1_r  <= sig_n_s;
            rnd1_r  <= rnd_n_s;
            stk1_r  <= stk_n_s;
            tiny1_r <= tiny_s;
            rm1_r   <= RM_SI;
            nan1_r  <= IsNaN_SI;
            inf1_r  <= IsInf_SI;
            zero1_r <= mant_zero_s;
        end else if (ld2_s) begin
            v1_r    <= 1'b0;
        end
    end

    // Round, detect overflow and apply special-value overrides.
    always_comb begin
        case (rm1_r)
            RM_RNE:  inc_s = rnd1_r & (stk1_r | sig1_r[0]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RUP:  inc_s = (rnd1_r | stk1_r) & ~sign1_r;
            RM_RDN:  inc_s = (rnd1_r | stk1_r) & sign1_r;
            default: inc_s = 1'b0;
        endcase
        // A denormal whose hidden bit becomes set rounds up to the minimum normal.
        sig_rnd_s = {1'b0, sig1_r} + (SIG_W+1)'(inc_s);
        exp_rnd_s = {1'b0, exp1_r} + (EXP_W+2)'(sig_rnd_s[SIG_W])
                  + (EXP_W+2)'(tiny1_r & sig_rnd_s[SIG_W-1]);
        nx_s  = rnd1_r | stk1_r;
        of_s  = (exp_rnd_s >= (EXP_W+2)'(EXP_INF));
        max_s = {sign1_r, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
        inf_s = {sign1_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        res_s = {sign1_r, exp_rnd_s[EXP_W-1:0], sig_rnd_s[MANT_W-1:0]};
        flags_s = {FLAG_W{1'b0}};
        if (nan1_r) begin
            res_s = NAN_PAT[RES_W-1:0];
        end else if (inf1_r) begin
            res_s = inf_s;
        end else if (zero1_r) begin
            res_s = {sign1_r, {(EXP_W+MANT_W){1'b0}}};
        end else if (of_s) begin
            flags_s[FLAG_OF] = 1'b1;
            flags_s[FLAG_NX] = 1'b1;
            case (rm1_r)
                RM_RNE:  res_s = inf_s;
                RM_RTZ:  res_s = max_s;
                RM_RUP:  res_s = sign1_r ? max_s : inf_s;
                RM_RDN:  res_s = sign1_r ? inf_s : max_s;
                default: res_s = inf_s;
            endcase
        end else begin
            flags_s[FLAG_NX] = nx_s;
            flags_s[FLAG_UF] = tiny1_r & nx_s;
        end
    end

    // Stage-2 output register: result and flags hold while the consumer stalls.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            v2_r    <= 1'b0;
            res_r   <= {RES_W{1'b0}};
            flags_r <= {FLAG_W{1'b0}};
        end else if (ld2_s) begin
            v2_r    <= 1'b1;
            res_r   <= res_s;
            flags_r <= flags_s;
        end else if (Out_Ready_SI) begin
            v2_r    <= 1'b0;
        end
    end

    assign Out_Valid_SO = v2_r;
    assign Res_DO       = res_r;
    assign OF_SO        = flags_r[FLAG_OF];
    assign UF_SO        = flags_r[FLAG_UF];
    assign NX_SO        = flags_r[FLAG_NX];

endmodule

// File: tb/tb_fpu_fmac_normround.sv
// Directed scoreboard bench for fpu_fmac_normround in binary32 configuration.
module tb_fpu_fmac_normround;

    localparam logic [48:0] M_ONE  = 49'd1 << 47;
    localparam logic [48:0] M_TWO  = 49'd1 << 48;
    localparam logic [48:0] M_TIE  = (49'd1 << 47) | (49'd1 << 23);
    localparam logic [48:0] M_ALL  = {49{1'b1}};
    localparam logic [48:0] M_ZERO = 49'd0;

    logic        Clk_CI = 1'b0;
    logic        Rst_RI;
    logic        In_Valid_SI, In_Ready_SO;
    logic        Sign_DI;
    logic [9:0]  Exp_DI;
    logic [48:0] Mant_DI;
    logic        Sticky_SI;
    logic [1:0]  RM_SI;
    logic        IsNaN_SI, IsInf_SI;
    logic        Out_Valid_SO, Out_Ready_SI;
    logic [31:0] Res_DO;
    logic        OF_SO, UF_SO, NX_SO;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          n_out = 0;
    bit          accepted;
    logic [31:0] cur_res;
    logic [2:0]  cur_flg;
    bit          cur_lat;

    fpu_fmac_normround dut (
        .Clk_CI       (Clk_CI),
        .Rst_RI       (Rst_RI),
        .In_Valid_SI  (In_Valid_SI),
        .In_Ready_SO  (In_Ready_SO),
        .Sign_DI      (Sign_DI),
        .Exp_DI       (Exp_DI),
        .Mant_DI      (Mant_DI),
        .Sticky_SI    (Sticky_SI),
        .RM_SI        (RM_SI),
        .IsNaN_SI     (IsNaN_SI),
        .IsInf_SI     (IsInf_SI),
        .Out_Valid_SO (Out_Valid_SO),
        .Out_Ready_SI (Out_Ready_SI),
        .Res_DO       (Res_DO),
        .OF_SO        (OF_SO),
        .UF_SO        (UF_SO),
        .NX_SO        (NX_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample both handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        accepted = 1'b0;
        @(negedge Clk_CI);
        if (!Rst_RI && In_Valid_SI && In_Ready_SO) begin
            accepted = 1'b1;
            sb_q.push_back('{res: cur_res, flg: cur_flg, acc: cyc, lat: cur_lat});
        end
        if (!Rst_RI && Out_Valid_SO && Out_Ready_SI) begin
            chk("out_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk($sformatf("res#%0d", n_out), 64'(Res_DO), 64'(e.res));
                chk($sformatf("flags#%0d", n_out), 64'({OF_SO, UF_SO, NX_SO}), 64'(e.flg));
                if (e.lat) begin
                    chk($sformatf("latency#%0d", n_out), 64'(cyc - e.acc), 64'd2);
                end
            end
            n_out++;
        end
        @(posedge Clk_CI);
        #1;
        cyc++;
        if (stall_cnt > 0) stall_cnt--;
        Out_Ready_SI = (stall_cnt == 0);
    endtask

    task automatic send(input logic s, input logic [9:0] e, input logic [48:0] m,
                        input logic st, input logic [1:0] rm, input logic nan,
                        input logic inf, input logic [31:0] eres,
                        input logic [2:0] eflg, input bit lat);
        Sign_DI = s; Exp_DI = e; Mant_DI = m; Sticky_SI = st; RM_SI = rm;
        IsNaN_SI = nan; IsInf_SI = inf; In_Valid_SI = 1'b1;
        cur_res = eres; cur_flg = eflg; cur_lat = lat;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) chk("accept_timeout", 64'(accepted), 64'd1);
    endtask

    task automatic drain();
        In_Valid_SI = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        Rst_RI = 1'b1; In_Valid_SI = 1'b0; Out_Ready_SI = 1'b1;
        Sign_DI = 1'b0; Exp_DI = 10'd0; Mant_DI = M_ZERO; Sticky_SI = 1'b0;
        RM_SI = 2'd0; IsNaN_SI = 1'b0; IsInf_SI = 1'b0;
        cur_res = 32'd0; cur_flg = 3'd0; cur_lat = 1'b0;
        repeat (2) @(posedge Clk_CI);
        #1;
        chk("rst_out_valid", 64'(Out_Valid_SO), 64'd0);
        chk("rst_res", 64'(Res_DO), 64'd0);
        chk("rst_flags", 64'({OF_SO, UF_SO, NX_SO}), 64'd0);
        Rst_RI = 1'b0;
        #1;
        chk("rst_in_ready", 64'(In_Ready_SO), 64'd1);

        // Back-to-back directed beats; flags are {OF, UF, NX}.
        send(1'b0, 10'sd127, M_ONE,  1'b0, 2'd0, 1'b0, 1'b0, 32'h3F800000, 3'b000, 1'b1);
        send(1'b0, 10'sd127, M_TWO,  1'b0, 2'd0, 1'b0, 1'b0, 32'h40000000, 3'b000, 1'b1);
        send(1'b0, 10'sd127, M_TIE,  1'b0, 2'd0, 1'b0, 1'b0, 32'h3F800000, 3'b001, 1'b1);
        send(1'b0, 10'sd127, M_TIE,  1'b0, 2'd2, 1'b0, 1'b0, 32'h3F800001, 3'b001, 1'b1);
        send(1'b1, 10'sd127, M_TIE,  1'b0, 2'd3, 1'b0, 1'b0, 32'hBF800001, 3'b001, 1'b1);
        send(1'b0, 10'sd255, M_ONE,  1'b0, 2'd0, 1'b0, 1'b0, 32'h7F800000, 3'b101, 1'b1);
        send(1'b0, 10'sd255, M_ONE,  1'b0, 2'd1, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b101, 1'b1);
        send(1'b1, 10'sd255, M_ONE,  1'b0, 2'd2, 1'b0, 1'b0, 32'hFF7FFFFF, 3'b101, 1'b1);
        send(1'b1, 10'sd255, M_ONE,  1'b0, 2'd3, 1'b0, 1'b0, 32'hFF800000, 3'b101, 1'b1);
        send(1'b0, -10'sd22, M_ONE,  1'b0, 2'd0, 1'b0, 1'b0, 32'h00000001, 3'b000, 1'b1);
        send(1'b0, -10'sd23, M_ONE,  1'b0, 2'd0, 1'b0, 1'b0, 32'h00000000, 3'b011, 1'b1);
        send(1'b0, -10'sd1,  M_ALL,  1'b0, 2'd0, 1'b0, 1'b0, 32'h00800000, 3'b011, 1'b1);
        send(1'b0, 10'sd127, M_ALL,  1'b0, 2'd0, 1'b0, 1'b0, 32'h40800000, 3'b001, 1'b1);
        send(1'b0, 10'sd127, M_ONE,  1'b1, 2'd1, 1'b0, 1'b0, 32'h3F800000, 3'b001, 1'b1);
        send(1'b1, 10'sd127, M_ONE,  1'b0, 2'd0, 1'b1, 1'b1, 32'h7FC00000, 3'b000, 1'b1);
        send(1'b1, 10'sd127, M_ONE,  1'b0, 2'd0, 1'b0, 1'b1, 32'hFF800000, 3'b000, 1'b1);
        send(1'b1, 10'sd127, M_ZERO, 1'b1, 2'd0, 1'b0, 1'b0, 32'h80000000, 3'b000, 1'b1);
        drain();

        // Back-pressure: consumer stalls for three cycles while four beats stream in.
        stall_cnt = 3;
        Out_Ready_SI = 1'b0;
        send(1'b0, 10'sd127, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h3F800000, 3'b000, 1'b0);
        send(1'b0, 10'sd128, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40000000, 3'b000, 1'b0);
        chk("bp_in_ready_low", 64'(In_Ready_SO), 64'd0);
        chk("bp_out_held", 64'(Out_Valid_SO), 64'd1);
        send(1'b0, 10'sd129, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40800000, 3'b000, 1'b0);
        send(1'b0, 10'sd126, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h3F000000, 3'b000, 1'b0);
        drain();

        // Reset with two beats in flight drops both; a later beat emerges alone.
        send(1'b0, 10'sd127, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h3F800000, 3'b000, 1'b1);
        send(1'b0, 10'sd128, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40000000, 3'b000, 1'b1);
        In_Valid_SI = 1'b0;
        Rst_RI = 1'b1;
        sb_q.delete();
        tick();
        chk("rst_mid_out_valid", 64'(Out_Valid_SO), 64'd0);
        chk("rst_mid_in_ready", 64'(In_Ready_SO), 64'd1);
        Rst_RI = 1'b0;
        send(1'b0, 10'sd129, M_ONE, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40800000, 3'b000, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) tick();
        chk("final_idle_valid", 64'(Out_Valid_SO), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
